// File: rtl/oven_pkg.sv
// oven_pkg: definitions shared by the oven front end and the setpoint block.
//   oven_state_e     key-conditioner FSM states
//   DEF_*            default timing constants, in clk cycles
//   max_int()        helper for sizing counters from several parameters
package oven_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PEND0,
    PEND1,
    HOLD0,
    HOLD1,
    WAIT_REL
  } oven_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_CHORD_WINDOW    = 2500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_RATE     = 5000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchroniser plus debouncer for one active-low raw key.
//   clk    system clock
//   rst    synchronous active-high reset
//   key_n  raw asynchronous key, 0 = pressed
//   held   debounced level, 1 = pressed
// The held level flips only after DEBOUNCE_CYCLES consecutive synchronised
// samples disagree with it; a single agreeing sample restarts the count.
module key_debounce
  import oven_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic held
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync_p0;
  logic            sync_p1;
  logic [DB_W-1:0] db_cnt;
  logic            pressed;

  function automatic logic [DB_W-1:0] sat_inc(input logic [DB_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign pressed = ~sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchroniser comes out of reset in the released state.
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      db_cnt  <= '0;
      held    <= 1'b0;
    end else begin
      // Stage p0/p1: metastability filter on the raw key.
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
      // Debounce stage on the synchronised level.
      if (pressed == held) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        held   <= pressed;
        db_cnt <= '0;
      end else begin
        db_cnt <= sat_inc(db_cnt);
      end
    end
  end

endmodule

// File: rtl/oven_key_conditioner.sv
// oven_key_conditioner: turns the two raw oven keys into one-cycle commands.
//   clk            system clock
//   rst            synchronous active-high reset
//   key0, key1     raw active-low keys (increment / decrement)
//   inc_pulse      one-cycle increment command (tap, window expiry, repeat)
//   dec_pulse      one-cycle decrement command
//   confirm_pulse  one-cycle command for a two-key chord
//   key0_held      debounced key0 level, 1 = pressed
//   key1_held      debounced key1 level, 1 = pressed
// A lone press is held back for CHORD_WINDOW cycles so a staggered chord never
// emits a step; after the window the step fires and auto-repeat begins.
module oven_key_conditioner
  import oven_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CHORD_WINDOW    = DEF_CHORD_WINDOW,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic key0,
  input  logic key1,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic confirm_pulse,
  output logic key0_held,
  output logic key1_held
);

  localparam int CNT_W =
    $clog2(max_int(max_int(CHORD_WINDOW, REPEAT_DELAY), REPEAT_RATE)) + 1;
  localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(CHORD_WINDOW - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  oven_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rep_q, rep_d;    // 0: waiting out REPEAT_DELAY, 1: REPEAT_RATE
  logic             inc_d, dec_d, conf_d;
  logic             p0, p1;
  logic             own, other, step, sel1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db0 (
    .clk   (clk),
    .rst   (rst),
    .key_n (key0),
    .held  (p0)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
    .clk   (clk),
    .rst   (rst),
    .key_n (key1),
    .held  (p1)
  );

  assign key0_held = p0;
  assign key1_held = p1;

  // Command stage: next state and next pulses from the debounced levels.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    conf_d  = 1'b0;
    step    = 1'b0;
    sel1    = (state_q == PEND1) || (state_q == HOLD1);
    own     = sel1 ? p1 : p0;
    other   = sel1 ? p0 : p1;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        rep_d = 1'b0;
        if (p0 && p1) begin
          conf_d  = 1'b1;
          state_d = WAIT_REL;
        end else if (p0) begin
          state_d = PEND0;
        end else if (p1) begin
          state_d = PEND1;
        end
      end
      PEND0, PEND1: begin
        // The other key wins over a release in the same cycle.
        if (other) begin
          conf_d  = 1'b1;
          state_d = WAIT_REL;
        end else if (!own) begin
          step    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == WIN_LAST) begin
          step    = 1'b1;
          state_d = sel1 ? HOLD1 : HOLD0;
          cnt_d   = '0;
          rep_d   = 1'b0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      HOLD0, HOLD1: begin
        if (other) begin
          state_d = WAIT_REL;
        end else if (!own) begin
          state_d = IDLE;
        end else if (cnt_q == (rep_q ? RATE_LAST : DELAY_LAST)) begin
          step  = 1'b1;
          cnt_d = '0;
          rep_d = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      WAIT_REL: begin
        if (!p0 && !p1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    inc_d = step && !sel1;
    dec_d = step && sel1;
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rep_q         <= 1'b0;
      inc_pulse     <= 1'b0;
      dec_pulse     <= 1'b0;
      confirm_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rep_q         <= rep_d;
      inc_pulse     <= inc_d;
      dec_pulse     <= dec_d;
      confirm_pulse <= conf_d;
    end
  end

endmodule

// File: tb/tb_oven_key_conditioner.sv
// Bench for oven_key_conditioner with small timing parameters. A timestamp
// based reference model predicts every output after every clock edge.
module tb_oven_key_conditioner;

  localparam int TB_DB = 4;
  localparam int TB_CW = 8;
  localparam int TB_RD = 20;
  localparam int TB_RR = 5;

  localparam int M_FREE  = 0;
  localparam int M_PEND  = 1;
  localparam int M_HOLD  = 2;
  localparam int M_CHORD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key0 = 1'b1;
  logic key1 = 1'b1;
  logic inc_pulse, dec_pulse, confirm_pulse, key0_held, key1_held;

  oven_key_conditioner #(
    .DEBOUNCE_CYCLES (TB_DB),
    .CHORD_WINDOW    (TB_CW),
    .REPEAT_DELAY    (TB_RD),
    .REPEAT_RATE     (TB_RR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key0          (key0),
    .key1          (key1),
    .inc_pulse     (inc_pulse),
    .dec_pulse     (dec_pulse),
    .confirm_pulse (confirm_pulse),
    .key0_held     (key0_held),
    .key1_held     (key1_held)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  // Reference model state.
  bit             mh [2];          // debounced levels
  bit [1:0]       mdl [2];         // raw values still in flight through the synchroniser
  bit [TB_DB-1:0] mhist [2];       // most recent synchronised "pressed" samples
  int             mns [2];         // samples seen since reset
  int             mode, who, t_start;
  bit             m_inc, m_dec, m_conf;

  // Scenario observations from the DUT.
  int  n_inc, n_dec, n_conf, n_h0;
  bit  prev_h1;
  int  fall1_edge, dec_edge, first_dec;
  bit  watch_dec;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mh[i] = 1'b0; mdl[i] = 2'b11; mhist[i] = '0; mns[i] = 0;
    end
    mode = M_FREE; who = 0; t_start = 0;
    m_inc = 1'b0; m_dec = 1'b0; m_conf = 1'b0;
  endtask

  // Predict outputs after the coming edge from the inputs present now.
  task automatic model_edge(input int n);
    bit own, oth, st;
    bit raw [2];
    int k;
    raw[0] = key0; raw[1] = key1;
    if (rst) begin
      model_reset();
      return;
    end
    m_inc = 1'b0; m_dec = 1'b0; m_conf = 1'b0; st = 1'b0;
    own = mh[who]; oth = mh[1 - who];
    case (mode)
      M_FREE: begin
        if (mh[0] && mh[1]) begin m_conf = 1'b1; mode = M_CHORD; end
        else if (mh[0] || mh[1]) begin who = mh[0] ? 0 : 1; mode = M_PEND; t_start = n; end
      end
      M_PEND: begin
        if (oth) begin m_conf = 1'b1; mode = M_CHORD; end
        else if (!own) begin st = 1'b1; mode = M_FREE; end
        else if (n - t_start == TB_CW) begin st = 1'b1; mode = M_HOLD; t_start = n; end
      end
      M_HOLD: begin
        k = n - t_start;
        if (oth) mode = M_CHORD;
        else if (!own) mode = M_FREE;
        else if (k == TB_RD || (k > TB_RD && (k - TB_RD) % TB_RR == 0)) st = 1'b1;
      end
      default: begin
        if (!mh[0] && !mh[1]) mode = M_FREE;
      end
    endcase
    if (st) begin
      if (who == 0) m_inc = 1'b1; else m_dec = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      mhist[i] = {mhist[i][TB_DB-2:0], ~mdl[i][1]};
      if (mns[i] < TB_DB) mns[i]++;
      if (mns[i] >= TB_DB && mhist[i] == (mh[i] ? {TB_DB{1'b0}} : {TB_DB{1'b1}}))
        mh[i] = ~mh[i];
      mdl[i] = {mdl[i][0], raw[i]};
    end
  endtask

  task automatic cmp(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_cnt, act, exp);
    end
  endtask

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    n_inc = 0; n_dec = 0; n_conf = 0; n_h0 = 0;
    fall1_edge = -1; dec_edge = -1; first_dec = -1; watch_dec = 1'b0;
  endtask

  // One clock: predict, let the edge happen, then compare every output.
  task automatic tick();
    model_edge(edge_cnt + 1);
    @(posedge clk);
    #1;
    edge_cnt++;
    cmp("inc_pulse", inc_pulse, m_inc);
    cmp("dec_pulse", dec_pulse, m_dec);
    cmp("confirm_pulse", confirm_pulse, m_conf);
    cmp("key0_held", key0_held, mh[0]);
    cmp("key1_held", key1_held, mh[1]);
    if (inc_pulse === 1'b1) n_inc++;
    if (dec_pulse === 1'b1) begin
      n_dec++;
      dec_edge = edge_cnt;
      if (watch_dec && first_dec < 0) first_dec = edge_cnt;
    end
    if (confirm_pulse === 1'b1) n_conf++;
    if (key0_held === 1'b1) n_h0++;
    if (prev_h1 && key1_held === 1'b0) fall1_edge = edge_cnt;
    prev_h1 = (key1_held === 1'b1);
  endtask

  task automatic settle();
    key0 = 1'b1; key1 = 1'b1;
    repeat (20) tick();
  endtask

  int rst_edge;
  int cd0, cd1;

  initial begin
    model_reset();
    prev_h1 = 1'b0;
    clear_obs();
    rst = 1'b1;
    repeat (3) tick();
    check_eq("reset_outputs",
             {27'd0, inc_pulse, dec_pulse, confirm_pulse, key0_held, key1_held}, 0);
    rst = 1'b0;
    repeat (5) tick();

    // Bounce rejection: runs of 2 never reach the 4-sample threshold.
    clear_obs();
    for (int i = 0; i < 10; i++) begin
      key0 = i[0];
      repeat (2) tick();
    end
    settle();
    check_eq("bounce_held_cycles", n_h0, 0);
    check_eq("bounce_pulses", n_inc + n_dec + n_conf, 0);

    // Short tap on key1, released well inside the chord window.
    clear_obs();
    key1 = 1'b0;
    repeat (6) tick();
    settle();
    check_eq("tap_dec_count", n_dec, 1);
    check_eq("tap_other_pulses", n_inc + n_conf, 0);
    check_eq("tap_dec_latency", dec_edge - fall1_edge, 1);

    // Hold key0 for 60 cycles: window pulse plus repeats at +20,+25..+50.
    clear_obs();
    key0 = 1'b0;
    repeat (60) tick();
    settle();
    check_eq("hold_inc_count", n_inc, 8);
    check_eq("hold_other_pulses", n_dec + n_conf, 0);

    // Staggered chord; key0 alone afterwards must stay silent until both release.
    clear_obs();
    key0 = 1'b0;
    repeat (3) tick();
    key1 = 1'b0;
    repeat (30) tick();
    key1 = 1'b1;
    repeat (25) tick();
    settle();
    check_eq("chord_confirm_count", n_conf, 1);
    check_eq("chord_step_pulses", n_inc + n_dec, 0);

    // Second key arrives after the window: no confirm, repeats stop.
    clear_obs();
    key0 = 1'b0;
    repeat (25) tick();
    key1 = 1'b0;
    repeat (20) tick();
    key0 = 1'b1;
    repeat (10) tick();
    settle();
    check_eq("late_inc_count", n_inc, 1);
    check_eq("late_confirm_dec", n_conf + n_dec, 0);

    // Reset during HOLD1 with key1 still pressed.
    clear_obs();
    key1 = 1'b0;
    repeat (18) tick();
    check_eq("pre_reset_dec", n_dec, 1);
    rst = 1'b1;
    tick();
    rst_edge = edge_cnt;
    check_eq("reset_mid_hold_outputs",
             {27'd0, inc_pulse, dec_pulse, confirm_pulse, key0_held, key1_held}, 0);
    rst = 1'b0;
    watch_dec = 1'b1;
    repeat (30) tick();
    check_eq("reset_redebounce_latency", first_dec - rst_edge, 15);
    settle();

    // Randomised key activity with occasional resets.
    cd0 = 0; cd1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (cd0 == 0) begin
        key0 = ~key0;
        cd0 = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 90) : $urandom_range(1, 25);
      end
      if (cd1 == 0) begin
        key1 = ~key1;
        cd1 = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 90) : $urandom_range(1, 25);
      end
      cd0--; cd1--;
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
